// File: rtl/p_keysch_inv_if.sv
// Bus between the decrypt key-schedule controller and p_keysch_inv.
// Master drives the serial key, the mode and the phase counter. Slave returns the round key and status.
interface p_keysch_inv_if;
    logic        data_in;
    logic [1:0]  data_rdy;
    logic [7:0]  counter;
    logic [63:0] key_out;
    logic        ff_done;
    logic        inv_done;

    modport master (
        output data_in, data_rdy, counter,
        input  key_out, ff_done, inv_done
    );

    modport slave (
        input  data_in, data_rdy, counter,
        output key_out, ff_done, inv_done
    );
endinterface

// File: rtl/p_keysch_inv.sv
// Inverse SIMON key schedule: serial key load, NROUNDS-cycle fast-forward, then one backward step per qualified request.
// Latency: key_out is KY straight from the register. ff_done rises NROUNDS clocks after the first FFWD clock.
// Backpressure: none. A serial-load cycle always wins and aborts any operation in progress.
module p_keysch_inv #(
    parameter int NROUNDS = 68
) (
    input  logic           clk,
    input  logic           rst_n,
    p_keysch_inv_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, FFWD = 2'd1, READY = 2'd2} state_t;

    localparam logic [6:0] LAST = 7'(NROUNDS - 1);

    state_t      state, state_nxt;
    logic [63:0] kx, ky, kx_nxt, ky_nxt;
    logic [6:0]  cnt, cnt_nxt;
    logic        ff_done_q, ff_nxt;
    logic        inv_done_q, inv_nxt;
    logic        unused_counter_hi;

    // Only counter[0] qualifies inverse steps.
    assign unused_counter_hi = ^bus.counter[7:1];

    function automatic logic [63:0] mix(input logic [63:0] x);
        return {x[2:0], x[63:3]} ^ {x[3:0], x[63:4]};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            kx         <= '0;
            ky         <= '0;
            cnt        <= '0;
            ff_done_q  <= 1'b0;
            inv_done_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            kx         <= kx_nxt;
            ky         <= ky_nxt;
            cnt        <= cnt_nxt;
            ff_done_q  <= ff_nxt;
            inv_done_q <= inv_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        kx_nxt    = kx;
        ky_nxt    = ky;
        cnt_nxt   = cnt;
        ff_nxt    = ff_done_q;
        inv_nxt   = inv_done_q;
        if (bus.data_rdy == 2'd2) begin
            // The first bit shifted in settles in KY[0], the last one in KX[63].
            {kx_nxt, ky_nxt} = {bus.data_in, kx, ky[63:1]};
            state_nxt = IDLE;
            cnt_nxt   = '0;
            ff_nxt    = 1'b0;
            inv_nxt   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.data_rdy == 2'd1) begin
                        state_nxt = FFWD;
                        cnt_nxt   = '0;
                    end
                end
                FFWD: begin
                    kx_nxt = ky ^ mix(kx);
                    ky_nxt = kx;
                    if (cnt == LAST) begin
                        state_nxt = READY;
                        cnt_nxt   = '0;
                        ff_nxt    = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 7'd1;
                    end
                end
                READY: begin
                    if (bus.data_rdy == 2'd3 && bus.counter[0] && !inv_done_q) begin
                        kx_nxt  = ky;
                        ky_nxt  = kx ^ mix(ky);
                        cnt_nxt = cnt + 7'd1;
                        if (cnt == LAST) inv_nxt = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign bus.key_out  = ky;
    assign bus.ff_done  = ff_done_q;
    assign bus.inv_done = inv_done_q;
endmodule

// File: doc/p_keysch_inv.md
Name: p_keysch_inv

Overview:
- Decryption-side SIMON key schedule. Counterpart of the team's forward (encryption) key schedule.
- Loads the same 128-bit master key over the same bit-serial interface.
- Fast-forwards NROUNDS forward rounds internally to reach the final key state.
- Then steps the schedule backwards, so key_out presents round keys in reverse order to the decryption datapath.
- Uses the same round function as the forward schedule: right-rotate-3 and right-rotate-4 XOR, no round constant.

Parameters:
- NROUNDS, 68: number of forward rounds fast-forwarded, and maximum number of inverse steps.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- data_in  in  1  serial key bit, valid when data_rdy==2
- data_rdy  in  2  mode: 0 hold, 1 start fast-forward, 2 serial load, 3 run inverse
- counter  in  8  round/phase counter from the controller; bit 0 qualifies inverse steps
- key_out  out  64  current round key (= KY)
- ff_done  out  1  high once fast-forward is complete and inverse stepping is permitted
- inv_done  out  1  high once NROUNDS inverse steps have been taken

Behaviour:
- Reset (async, rst_n=0):
  - KX=0, KY=0, fwd/inv count=0.
  - state=IDLE.
  - ff_done=0, inv_done=0, key_out=0.
- Registers: KX[63:0], KY[63:0], 7-bit round count, FSM {IDLE, FFWD, READY}.
- Notation: ror(x,n) = {x[n-1:0], x[63:n]}.
  - Forward round: KX <= KY ^ ror(KX,3) ^ ror(KX,4); KY <= KX.
  - Inverse round: KX <= KY; KY <= KX ^ ror(KY,3) ^ ror(KY,4).
- data_rdy==2 (any state, highest priority):
  - {KX,KY} <= {data_in, KX, KY[63:1]}.
  - 128 cycles load a full key; the first bit sent ends in KY[0], the last in KX[63].
  - Forces state=IDLE, count=0, ff_done=0, inv_done=0.
  - A load during FFWD or READY aborts that operation.
- IDLE:
  - data_rdy==1: go to FFWD, count=0.
  - data_rdy==0 or 3: hold all registers.
- FFWD:
  - One forward round every clock, independent of counter and of data_rdy (except 2).
  - After exactly NROUNDS rounds: state=READY, count=0, ff_done=1 on the cycle following the last round.
  - Total latency: NROUNDS cycles from the first FFWD clock.
- READY:
  - data_rdy==3 and counter[0]==1 and inv_done==0: one inverse round, count++.
  - When count reaches NROUNDS, inv_done=1. Further inverse requests are ignored and the state holds (equals the loaded key).
  - data_rdy==3 with counter[0]==0: hold.
  - data_rdy==1 in READY: ignored; a reload is required to restart.
- key_out = KY, combinational from the register, no extra latency.
  - Immediately after ff_done rises, key_out = KY after NROUNDS forward rounds.
  - After k inverse steps, key_out = forward KY at round NROUNDS-k.
- ff_done and inv_done are registered and hold until reset or a data_rdy==2 cycle.
- Reset asserted mid-FFWD or mid-inverse: immediate return to the reset values; the key is lost.

Test Plan:
- Reset/hold:
  - rst_n pulse low mid-operation → key_out=0, ff_done=0, inv_done=0 asynchronously.
  - data_rdy=0 for 10 cycles → no change.
- Serial load order:
  - Send 1 then 127 zeros with data_rdy=2 → KY=64'h1, KX=0, key_out=64'h1.
  - Send 64 zeros then 1 then 63 zeros → KX=64'h1, KY=0.
- Single round (NROUNDS=1):
  - Load KX=0, KY=1; data_rdy=1 → after 1 cycle ff_done=1, key_out=0 (KX=1).
  - Then data_rdy=3, counter=1 → key_out=64'h1, inv_done=1.
  - A second step is ignored.
- counter gating:
  - In READY, data_rdy=3 with counter stepping 0..7 → exactly 4 inverse steps, taken on the odd counter values.
- Round trip (NROUNDS=68, random key):
  - After load and fast-forward, key_out equals the forward reference model's KY at round 68.
  - Each subsequent odd-counter step yields the reference KY at rounds 67, 66, …, 0.
  - After 68 steps, KX/KY equal the loaded key and inv_done=1.
- Abort:
  - data_rdy=2 asserted at FFWD round 30 → state IDLE, ff_done stays 0, the shift occurs.
  - Full reload then fast-forward → correct final key, as in the round-trip test.
